// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) multisquare datapath.
// Field: x^163 + x^7 + x^6 + x^3 + 1; the x^163 term is implicit in GF_POLY.
package gf163_pkg;

  localparam int GF_M = 163;

  typedef logic [GF_M-1:0] gf163_t;

  localparam gf163_t GF_POLY = gf163_t'(8'hC9);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } msq_state_t;

endpackage

// File: rtl/square.sv
// Combinational squarer in GF(2^163): spread bits to even positions, then reduce.
// Squaring is linear in GF(2), so the whole block collapses to an XOR network.
module square
  import gf163_pkg::*;
(
  input  gf163_t a,
  output gf163_t b
);

  logic [2*GF_M-2:0] wide;

  always_comb begin
    // NOTE: blocking assignments in always_comb, with wide given a value first, so
    // each fold sees the previous one and no latch is inferred.
    wide = '0;
    for (int i = 0; i < GF_M; i++) begin
      wide[2*i] = a[i];
    end
    // Fold from the top down; a fold can land above GF_M-1 and is folded again later.
    for (int i = 2*GF_M-2; i >= GF_M; i--) begin
      if (wide[i]) begin
        wide[i] = 1'b0;
        for (int j = 0; j < GF_M; j++) begin
          if (GF_POLY[j]) wide[i-GF_M+j] = ~wide[i-GF_M+j];
        end
      end
    end
    b = wide[GF_M-1:0];
  end

endmodule

// File: rtl/gf163_multisquare.sv
// Sequential k-fold squarer: msq_b = msq_a^(2^K) using SQ_PER_CYC chained squarers per clock.
// Optional macro GF163_MSQ_ABORT_EN adds an abort input that cancels a job in RUN or DONE.
module gf163_multisquare
  import gf163_pkg::*;
#(
  parameter int SQ_PER_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_rdy,
  input  gf163_t           msq_a,
  input  logic [CNT_W-1:0] msq_k,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GF163_MSQ_ABORT_EN
  input  logic             abort,
`endif
  output gf163_t           msq_b
);

  if (SQ_PER_CYC < 1 || SQ_PER_CYC > 4) begin : g_bad_param
    $error("SQ_PER_CYC must be in 1..4");
  end

  msq_state_t                       state;
  gf163_t                           acc;
  logic [CNT_W-1:0]                 cnt;
  logic [CNT_W-1:0]                 step;
  logic [SQ_PER_CYC:0][GF_M-1:0]    taps;
  gf163_t                           next_acc;
  logic                             last_step;
  logic                             kill;

  assign taps[0] = acc;

  for (genvar g = 0; g < SQ_PER_CYC; g++) begin : g_chain
    square u_sq (
      .a (taps[g]),
      .b (taps[g+1])
    );
  end

  // Tap mux: use the full chain unless fewer squarings remain.
  always_comb begin
    next_acc = taps[SQ_PER_CYC];
    step     = CNT_W'(SQ_PER_CYC);
    for (int i = 1; i < SQ_PER_CYC; i++) begin
      if (cnt == CNT_W'(i)) begin
        next_acc = taps[i];
        step     = CNT_W'(i);
      end
    end
  end

  assign last_step = (cnt == step);
  assign start_rdy = (state == IDLE) && !rst;

`ifdef GF163_MSQ_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      msq_b     <= '0;
    end else if (kill) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      msq_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= msq_a;
            cnt <= msq_k;
            if (msq_k == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              msq_b     <= msq_a;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= next_acc;
          cnt <= cnt - step;
          if (last_step) begin
            state     <= DONE;
            out_valid <= 1'b1;
            msq_b     <= next_acc;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf163_multisquare.sv
// Self-checking bench for gf163_multisquare against a shift-and-add GF(2^163) model.
// Instances: dut (SQ_PER_CYC=1) and dut3 (SQ_PER_CYC=3); honours GF163_MSQ_ABORT_EN.
module tb_gf163_multisquare;

  typedef logic [162:0] gf_t;

  localparam gf_t POLY_LOW = 163'hC9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_rdy;
  gf_t        msq_a = '0;
  logic [7:0] msq_k = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  gf_t        msq_b;
  logic       abort = 1'b0;

  logic       s3_start = 1'b0;
  logic       s3_rdy;
  gf_t        s3_a = '0;
  logic [7:0] s3_k = '0;
  logic       s3_valid;
  logic       s3_ready = 1'b0;
  gf_t        s3_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_accept = 0;

  gf163_multisquare dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_rdy (start_rdy),
    .msq_a     (msq_a),
    .msq_k     (msq_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GF163_MSQ_ABORT_EN
    .abort     (abort),
`endif
    .msq_b     (msq_b)
  );

  gf163_multisquare #(.SQ_PER_CYC(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (s3_start),
    .start_rdy (s3_rdy),
    .msq_a     (s3_a),
    .msq_k     (s3_k),
    .out_valid (s3_valid),
    .out_ready (s3_ready),
`ifdef GF163_MSQ_ABORT_EN
    .abort     (1'b0),
`endif
    .msq_b     (s3_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cycle);
    $fatal(1);
  end

  // Reference arithmetic: multiply by x with reduction, shift-and-add multiply.
  function automatic gf_t gf_mulx(input gf_t v);
    return (v << 1) ^ (v[162] ? POLY_LOW : '0);
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = gf_mulx(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic gf_t model_msq(input gf_t a, input int k);
    gf_t r = a;
    for (int i = 0; i < k; i++) r = gf_mul(r, r);
    return r;
  endfunction

  function automatic gf_t rand_gf();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[162:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Runs one job on dut; checks handshake rules along the way.
  task automatic run_job(input gf_t a, input logic [7:0] k, input int stall, input bit poke,
                         output int lat, output gf_t res);
    int guard = 0;
    lat = -1;
    res = '0;
    while (!start_rdy && guard < 300) begin
      tick();
      guard++;
    end
    checks++;
    if (start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_timeout got=%b want=1", start_rdy);
      return;
    end
    start = 1'b1;
    msq_a = a;
    msq_k = k;
    last_accept = cycle;
    tick();
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      checks++;
      if (start_rdy !== 1'b0) begin
        errors++;
        $display("FAIL busy_rdy got=%b want=0 lat=%0d", start_rdy, lat);
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        msq_a = rand_gf();
        msq_k = 8'($urandom());
      end
      tick();
      lat++;
    end
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got=%b want=1 k=%0d", out_valid, k);
      return;
    end
    res = msq_b;
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        start = 1'b1;
        msq_a = rand_gf();
        msq_k = 8'($urandom());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || msq_b !== res || start_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold valid=%b rdy=%b b=%h want_b=%h", out_valid, start_rdy, msq_b, res);
      end
    end
    // A start alongside out_ready must not be taken; the block must be idle afterwards.
    out_ready = 1'b1;
    start = 1'b1;
    msq_a = rand_gf();
    msq_k = 8'd1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || start_rdy !== 1'b1 || msq_b !== res) begin
      errors++;
      $display("FAIL handoff valid=%b rdy=%b b=%h want valid=0 rdy=1 b=%h",
               out_valid, start_rdy, msq_b, res);
    end
  endtask

  task automatic run_job3(input gf_t a, input logic [7:0] k, output int lat, output gf_t res);
    lat = -1;
    res = '0;
    s3_start = 1'b1;
    s3_a = a;
    s3_k = k;
    tick();
    s3_start = 1'b0;
    lat = 1;
    while (!s3_valid && lat < 400) begin
      tick();
      lat++;
    end
    res = s3_b;
    s3_ready = 1'b1;
    tick();
    s3_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (start_rdy !== 1'b0 || out_valid !== 1'b0 || msq_b !== '0 || s3_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b valid=%b b=%h rdy3=%b want 0/0/0/0",
               start_rdy, out_valid, msq_b, s3_rdy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (start_rdy !== 1'b1 || s3_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release rdy=%b rdy3=%b want 1/1", start_rdy, s3_rdy);
    end
    tick();
  endtask

  task automatic test_basic();
    int  lat;
    gf_t res;
    gf_t x82 = '0;
    gf_t exp82 = '0;
    run_job(163'd1, 8'd5, 0, 1'b0, lat, res);
    checks++;
    if (lat !== 6 || res !== 163'd1) begin
      errors++;
      $display("FAIL one_k5 lat=%0d b=%h want lat=6 b=1", lat, res);
    end
    x82[82] = 1'b1;
    exp82[8] = 1'b1;
    exp82[7] = 1'b1;
    exp82[4] = 1'b1;
    exp82[1] = 1'b1;
    run_job(x82, 8'd1, 2, 1'b1, lat, res);
    checks++;
    if (res !== exp82 || res !== model_msq(x82, 1) || lat !== 2) begin
      errors++;
      $display("FAIL x82_sq lat=%0d b=%h want lat=2 b=%h", lat, res, exp82);
    end
  endtask

  task automatic test_k0_hold();
    int  lat;
    gf_t res;
    run_job(163'd2, 8'd0, 10, 1'b1, lat, res);
    checks++;
    if (lat !== 1 || res !== 163'd2) begin
      errors++;
      $display("FAIL k0 lat=%0d b=%h want lat=1 b=2", lat, res);
    end
  endtask

  task automatic test_frobenius();
    int  lat;
    gf_t res;
    gf_t a = rand_gf();
    int  ks[4] = '{163, 200, 2, 4};
    run_job(a, 8'd163, 0, 1'b0, lat, res);
    checks++;
    if (lat !== 164 || res !== a) begin
      errors++;
      $display("FAIL frob1 lat=%0d b=%h want lat=164 b=%h", lat, res, a);
    end
    foreach (ks[i]) begin
      a = rand_gf();
      run_job3(a, 8'(ks[i]), lat, res);
      checks++;
      if (lat !== (ks[i] + 2) / 3 + 1 || res !== model_msq(a, ks[i])) begin
        errors++;
        $display("FAIL sq3 k=%0d lat=%0d b=%h want lat=%0d b=%h",
                 ks[i], lat, res, (ks[i] + 2) / 3 + 1, model_msq(a, ks[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    gf_t res;
    int  prev;
    run_job(rand_gf(), 8'd3, 0, 1'b0, lat, res);
    prev = last_accept;
    for (int j = 0; j < 3; j++) begin
      gf_t a = rand_gf();
      run_job(a, 8'd3, 0, 1'b0, lat, res);
      checks++;
      if (last_accept - prev !== 5 || res !== model_msq(a, 3)) begin
        errors++;
        $display("FAIL b2b period=%0d want=5 b=%h want_b=%h", last_accept - prev, res, model_msq(a, 3));
      end
      prev = last_accept;
    end
  endtask

  task automatic test_random();
    int  lat;
    gf_t res;
    int  bad = 0;
    for (int j = 0; j < 1000; j++) begin
      gf_t a = rand_gf();
      int  k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
      run_job(a, 8'(k), $urandom_range(0, 3), 1'b1, lat, res);
      checks++;
      if (res !== model_msq(a, k) || lat !== k + 1) begin
        errors++;
        if (bad < 5)
          $display("FAIL random job=%0d k=%0d lat=%0d b=%h want lat=%0d b=%h",
                   j, k, lat, res, k + 1, model_msq(a, k));
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int  lat;
    gf_t res;
    gf_t a;
    run_job(rand_gf() | 163'd1, 8'd3, 0, 1'b0, lat, res);
    start = 1'b1;
    msq_a = rand_gf();
    msq_k = 8'd100;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || msq_b !== '0 || start_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid valid=%b b=%h rdy=%b want 0/0/0", out_valid, msq_b, start_rdy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (start_rdy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle rdy=%b valid=%b want 1/0", start_rdy, out_valid);
    end
    a = rand_gf();
    run_job(a, 8'd7, 0, 1'b0, lat, res);
    checks++;
    if (res !== model_msq(a, 7) || lat !== 8) begin
      errors++;
      $display("FAIL rst_after lat=%0d b=%h want lat=8 b=%h", lat, res, model_msq(a, 7));
    end
  endtask

`ifdef GF163_MSQ_ABORT_EN
  task automatic test_abort();
    int  lat;
    gf_t res;
    gf_t a;
    gf_t keep;
    run_job(rand_gf() | 163'd1, 8'd2, 0, 1'b0, lat, res);
    keep = msq_b;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (msq_b !== keep || start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle b=%h rdy=%b want b=%h rdy=1", msq_b, start_rdy, keep);
    end
    start = 1'b1;
    msq_a = rand_gf();
    msq_k = 8'd50;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || msq_b !== '0 || start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_run valid=%b b=%h rdy=%b want 0/0/1", out_valid, msq_b, start_rdy);
    end
    a = rand_gf();
    run_job(a, 8'd9, 0, 1'b0, lat, res);
    checks++;
    if (res !== model_msq(a, 9) || lat !== 10) begin
      errors++;
      $display("FAIL abort_after lat=%0d b=%h want lat=10 b=%h", lat, res, model_msq(a, 9));
    end
    // Abort in DONE wins over a simultaneous out_ready.
    start = 1'b1;
    msq_a = rand_gf() | 163'd1;
    msq_k = 8'd0;
    tick();
    start = 1'b0;
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || msq_b !== '0) begin
      errors++;
      $display("FAIL abort_done valid=%b b=%h want 0/0", out_valid, msq_b);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_k0_hold();
    test_frobenius();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
`ifdef GF163_MSQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
